// File: rtl/pellet_score.sv
// pellet_score: pellet bookkeeping and BCD score stage ahead of drawcon.
// Keeps a per-tile eaten map and the remaining-pellet count, and answers
// per-tile eaten queries for the renderer with one cycle of latency.
// Optional feature macro: PELLET_SCORE_CLEAR_BONUS_EN. When it is defined,
// eating the last pellet adds 101 to the score instead of 1.
module pellet_score #(
  parameter int MAP_ROWS = 50,
  parameter int MAP_COLS = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         pacman_blkpos_x,
  input  logic [9:0]          pacman_blkpos_y,
  input  logic                pos_valid,
  output logic                ready,
  output logic [5:0]          map_addr,
  input  logic [MAP_COLS-1:0] map_row,
  input  logic [6:0]          disp_tile_x,
  input  logic [5:0]          disp_tile_y,
  output logic                pellet_eaten,
  output logic [15:0]         score,
  output logic [11:0]         remaining,
  output logic                eat_pulse,
  output logic                all_clear
);

  localparam logic [5:0]  ROWS6  = 6'(MAP_ROWS);
  localparam logic [6:0]  COLS7  = 7'(MAP_COLS);
  localparam logic [10:0] ROWS11 = 11'(MAP_ROWS);
  localparam logic [11:0] COLS12 = 12'(MAP_COLS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FETCH, S_CHECK} state_t;

  state_t                             state_q;
  logic [5:0]                         clr_cnt_q;
  logic [6:0]                         tx_q;
  logic [5:0]                         ty_q;
  logic [15:0]                        score_q;
  logic [11:0]                        remaining_q;
  logic                               eat_pulse_q;
  logic                               all_clear_q;
  logic                               pellet_eaten_q;
  logic [MAP_ROWS-1:0][MAP_COLS-1:0]  eaten_q;

  // 4-digit BCD add with ripple carry; carry out of the top digit is dropped
  // so the result wraps modulo 10000.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        c;
    logic [4:0]  d;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[i*4 +: 4] = d[3:0];
    end
    return s;
  endfunction

  // Number of pellets in one ROM row.
  function automatic logic [11:0] popcnt(input logic [MAP_COLS-1:0] v);
    logic [11:0] n;
    n = '0;
    for (int i = 0; i < MAP_COLS; i++) n = n + {11'b0, v[i]};
    return n;
  endfunction

  // Tile under the sprite centre (origin + half a 16-pixel tile).
  logic [11:0] tx_sum, tx_w;
  logic [10:0] ty_sum, ty_w;
  logic        tile_in_range;
  assign tx_sum        = {1'b0, pacman_blkpos_x} + 12'd8;
  assign ty_sum        = {1'b0, pacman_blkpos_y} + 11'd8;
  assign tx_w          = tx_sum >> 4;
  assign ty_w          = ty_sum >> 4;
  assign tile_in_range = (tx_w < COLS12) && (ty_w < ROWS11);

  logic [11:0] rem_clear_d;
  logic        hit;
  logic [15:0] score_step;
  logic [15:0] score_d;
  assign rem_clear_d = remaining_q + popcnt(map_row);
  assign hit         = map_row[tx_q] & ~eaten_q[ty_q][tx_q];

`ifdef PELLET_SCORE_CLEAR_BONUS_EN
  // The pellet that empties the board is worth 1 plus a 100 bonus.
  assign score_step = (remaining_q == 12'd1) ? 16'h0101 : 16'h0001;
`else
  assign score_step = 16'h0001;
`endif
  assign score_d = bcd_add(score_q, score_step);

  // ROM row address: sweep rows while clearing, the latched row while fetching.
  always_comb begin
    map_addr = '0;
    case (state_q)
      S_CLEAR: if (clr_cnt_q < ROWS6) map_addr = clr_cnt_q;
      S_FETCH: map_addr = ty_q;
      default: map_addr = '0;
    endcase
  end

  // Main FSM: clear/count sweep, then accept, fetch and check positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      score_q     <= '0;
      remaining_q <= '0;
      eat_pulse_q <= 1'b0;
      all_clear_q <= 1'b0;
    end else begin
      eat_pulse_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q < ROWS6) eaten_q[clr_cnt_q] <= '0;
          // map_row lags the address by one cycle, so count starts at c=1.
          if (clr_cnt_q != 6'd0) remaining_q <= rem_clear_d;
          if (clr_cnt_q == ROWS6) begin
            state_q     <= S_IDLE;
            all_clear_q <= (rem_clear_d == 12'd0);
          end else begin
            clr_cnt_q <= clr_cnt_q + 6'd1;
          end
        end
        S_IDLE: begin
          if (pos_valid) begin
            tx_q <= tx_w[6:0];
            ty_q <= ty_w[5:0];
            if (tile_in_range) state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_CHECK;
        S_CHECK: begin
          if (hit) begin
            eaten_q[ty_q][tx_q] <= 1'b1;
            score_q             <= score_d;
            remaining_q         <= remaining_q - 12'd1;
            eat_pulse_q         <= 1'b1;
            all_clear_q         <= (remaining_q == 12'd1);
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Renderer lookup: registered, independent of the FSM, 0 off the map.
  always_ff @(posedge clk) begin
    if (rst) begin
      pellet_eaten_q <= 1'b0;
    end else if ((disp_tile_y < ROWS6) && (disp_tile_x < COLS7)) begin
      pellet_eaten_q <= eaten_q[disp_tile_y][disp_tile_x];
    end else begin
      pellet_eaten_q <= 1'b0;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign score        = score_q;
  assign remaining    = remaining_q;
  assign eat_pulse    = eat_pulse_q;
  assign all_clear    = all_clear_q;
  assign pellet_eaten = pellet_eaten_q;

endmodule

// File: tb/tb_pellet_score.sv
// Directed bench for pellet_score with a 1-cycle-latency map ROM model
// holding 37 pellets (rows 0, 1, 10 and 49).
module tb_pellet_score;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] px = '0;
  logic [9:0]  py = '0;
  logic        pos_valid = 1'b0;
  logic        ready;
  logic [5:0]  map_addr;
  logic [79:0] map_row;
  logic [6:0]  dtx = '0;
  logic [5:0]  dty = '0;
  logic        pellet_eaten;
  logic [15:0] score;
  logic [11:0] remaining;
  logic        eat_pulse;
  logic        all_clear;

  int checks = 0;
  int errors = 0;

  logic [79:0] rom [0:63];

  pellet_score #(.MAP_ROWS(50), .MAP_COLS(80)) dut (
    .clk(clk), .rst(rst),
    .pacman_blkpos_x(px), .pacman_blkpos_y(py), .pos_valid(pos_valid),
    .ready(ready), .map_addr(map_addr), .map_row(map_row),
    .disp_tile_x(dtx), .disp_tile_y(dty), .pellet_eaten(pellet_eaten),
    .score(score), .remaining(remaining), .eat_pulse(eat_pulse),
    .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  // Map ROM: one cycle read latency.
  always @(posedge clk) map_row <= rom[map_addr];

  // Strobe a pixel position for one cycle (call at a negedge while IDLE).
  task automatic strobe(input int x, input int y);
    px = 11'(x);
    py = 10'(y);
    pos_valid = 1'b1;
    @(posedge clk);
    #1 pos_valid = 1'b0;
  endtask

  // Strobe a tile and return at the negedge of N+3.
  task automatic eat_tile(input int tx, input int ty);
    strobe(tx * 16, ty * 16);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h want 0", ready); end
    checks++; if (map_addr !== 6'd0) begin errors++; $display("FAIL rst_map_addr got %0h want 0", map_addr); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL rst_score got %0h want 0", score); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL rst_remaining got %0d want 0", remaining); end
    checks++; if (eat_pulse !== 1'b0) begin errors++; $display("FAIL rst_eat_pulse got %0h want 0", eat_pulse); end
    checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL rst_all_clear got %0h want 0", all_clear); end
    checks++; if (pellet_eaten !== 1'b0) begin errors++; $display("FAIL rst_pellet_eaten got %0h want 0", pellet_eaten); end
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
      if (k < 50 && map_addr !== 6'(k)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sweep got %0d bad cycles want 0", bad); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_cycle51 got %0h want 1", ready); end
    checks++; if (remaining !== 12'd37) begin errors++; $display("FAIL init_remaining got %0d want 37", remaining); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL init_score got %0h want 0", score); end
    checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL init_all_clear got %0h want 0", all_clear); end
  endtask

  task automatic test_eat_first();
    strobe(24, 8);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fetch_ready got %0h want 0", ready); end
    checks++; if (map_addr !== 6'd1) begin errors++; $display("FAIL fetch_addr got %0d want 1", map_addr); end
    @(negedge clk);
    checks++; if (eat_pulse !== 1'b0) begin errors++; $display("FAIL early_pulse got %0h want 0", eat_pulse); end
    @(negedge clk);
    checks++; if (eat_pulse !== 1'b1) begin errors++; $display("FAIL first_pulse got %0h want 1", eat_pulse); end
    checks++; if (score !== 16'h0001) begin errors++; $display("FAIL first_score got %0h want 0001", score); end
    checks++; if (remaining !== 12'd36) begin errors++; $display("FAIL first_remaining got %0d want 36", remaining); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL first_ready got %0h want 1", ready); end
    @(negedge clk);
    checks++; if (eat_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width got %0h want 0", eat_pulse); end
    dtx = 7'd2; dty = 6'd1;
    @(negedge clk);
    checks++; if (pellet_eaten !== 1'b1) begin errors++; $display("FAIL disp_2_1 got %0h want 1", pellet_eaten); end
    dtx = 7'd3;
    @(negedge clk);
    checks++; if (pellet_eaten !== 1'b0) begin errors++; $display("FAIL disp_3_1 got %0h want 0", pellet_eaten); end
    dtx = 7'd100;
    @(negedge clk);
    checks++; if (pellet_eaten !== 1'b0) begin errors++; $display("FAIL disp_oob got %0h want 0", pellet_eaten); end
  endtask

  task automatic test_repeat();
    int pulses;
    pulses = 0;
    strobe(24, 8);
    repeat (3) begin
      @(negedge clk);
      if (eat_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL repeat_pulses got %0d want 0", pulses); end
    checks++; if (score !== 16'h0001) begin errors++; $display("FAIL repeat_score got %0h want 0001", score); end
    checks++; if (remaining !== 12'd36) begin errors++; $display("FAIL repeat_remaining got %0d want 36", remaining); end
  endtask

  task automatic test_bcd_carry();
    for (int c = 3; c <= 10; c++) eat_tile(c, 1);
    checks++; if (score !== 16'h0009) begin errors++; $display("FAIL score_nine got %0h want 0009", score); end
    eat_tile(11, 1);
    checks++; if (score !== 16'h0010) begin errors++; $display("FAIL score_carry got %0h want 0010", score); end
    checks++; if (remaining !== 12'd27) begin errors++; $display("FAIL carry_remaining got %0d want 27", remaining); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    px = 11'(12 * 16); py = 10'd16; pos_valid = 1'b1;
    @(posedge clk);
    #1 px = 11'(13 * 16);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %0h want 0", ready); end
    @(negedge clk);
    if (eat_pulse === 1'b1) pulses++;
    @(posedge clk);
    #1 pos_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (eat_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (remaining !== 12'd26) begin errors++; $display("FAIL b2b_remaining got %0d want 26", remaining); end
    checks++; if (score !== 16'h0011) begin errors++; $display("FAIL b2b_score got %0h want 0011", score); end
    dtx = 7'd13; dty = 6'd1;
    @(negedge clk);
    checks++; if (pellet_eaten !== 1'b0) begin errors++; $display("FAIL b2b_dropped_tile got %0h want 0", pellet_eaten); end
    dtx = 7'd12;
    @(negedge clk);
    checks++; if (pellet_eaten !== 1'b1) begin errors++; $display("FAIL b2b_taken_tile got %0h want 1", pellet_eaten); end
  endtask

  task automatic test_out_of_range();
    strobe(2000, 8);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL oob_x_ready got %0h want 1", ready); end
    repeat (2) @(negedge clk);
    checks++; if (score !== 16'h0011) begin errors++; $display("FAIL oob_x_score got %0h want 0011", score); end
    checks++; if (remaining !== 12'd26) begin errors++; $display("FAIL oob_x_remaining got %0d want 26", remaining); end
    strobe(1272, 16);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL oob_x80_ready got %0h want 1", ready); end
    strobe(24, 800);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL oob_y50_ready got %0h want 1", ready); end
    repeat (2) @(negedge clk);
    checks++; if (remaining !== 12'd26) begin errors++; $display("FAIL oob_remaining got %0d want 26", remaining); end
    eat_tile(79, 49);
    checks++; if (score !== 16'h0012) begin errors++; $display("FAIL corner_score got %0h want 0012", score); end
    checks++; if (remaining !== 12'd25) begin errors++; $display("FAIL corner_remaining got %0d want 25", remaining); end
  endtask

  task automatic test_rst_in_check();
    int bad;
    strobe(0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL midrst_score got %0h want 0", score); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL midrst_remaining got %0d want 0", remaining); end
    checks++; if (eat_pulse !== 1'b0) begin errors++; $display("FAIL midrst_pulse got %0h want 0", eat_pulse); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0h want 0", ready); end
    repeat (50) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_c50_ready got %0h want 0", ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_c51_ready got %0h want 1", ready); end
    checks++; if (remaining !== 12'd37) begin errors++; $display("FAIL midrst_count got %0d want 37", remaining); end
    bad = 0;
    for (int r = 0; r < 50; r++) begin
      for (int c = 0; c < 80; c++) begin
        dtx = 7'(c); dty = 6'(r);
        @(negedge clk);
        if (pellet_eaten !== 1'b0) bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_eaten got %0d set tiles want 0", bad); end
  endtask

  task automatic test_eat_all();
    int exp_rem, bad;
    logic [15:0] exp_final;
`ifdef PELLET_SCORE_CLEAR_BONUS_EN
    exp_final = 16'h0137;
`else
    exp_final = 16'h0037;
`endif
    exp_rem = 37;
    bad = 0;
    for (int r = 0; r < 50; r++) begin
      for (int c = 0; c < 80; c++) begin
        if (rom[r][c]) begin
          if (exp_rem == 1) begin
            checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL pre_last_all_clear got %0h want 0", all_clear); end
          end
          eat_tile(c, r);
          exp_rem--;
          if (remaining !== 12'(exp_rem) || eat_pulse !== 1'b1) bad++;
        end
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL eat_all_steps got %0d bad want 0", bad); end
    checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL all_clear got %0h want 1", all_clear); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL final_remaining got %0d want 0", remaining); end
    checks++; if (score !== exp_final) begin errors++; $display("FAIL final_score got %0h want %0h", score, exp_final); end
    @(negedge clk);
    checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL all_clear_hold got %0h want 1", all_clear); end
    checks++; if (eat_pulse !== 1'b0) begin errors++; $display("FAIL final_pulse_width got %0h want 0", eat_pulse); end
  endtask

  initial begin
    for (int r = 0; r < 64; r++) rom[r] = '0;
    for (int c = 0; c <= 4; c++)   rom[0][c]  = 1'b1;
    for (int c = 2; c <= 13; c++)  rom[1][c]  = 1'b1;
    for (int c = 20; c <= 34; c++) rom[10][c] = 1'b1;
    for (int c = 75; c <= 79; c++) rom[49][c] = 1'b1;
    test_reset();
    test_eat_first();
    test_repeat();
    test_bcd_carry();
    test_back_to_back();
    test_out_of_range();
    test_rst_in_check();
    test_eat_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
